counter_ctrl: RTL and testbench

Command-driven sequencer for the team's 8-bit up/down position counter. It accepts move commands over a valid/ready handshake: load, step up N, step down N, or go to a target. It steps the internal count one unit per STEP_DIV clocks, in the commanded direction, and saturates at programmable limits. It sits between a host or register block and any logic that consumes a stepped count value.

---
 rtl/counter_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_counter_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for an up/down position counter.
//
// A host issues move commands over a valid/ready handshake. The count is
// stepped one unit every STEP_DIV clocks in the commanded direction and
// saturates at [LIMIT_LO, LIMIT_HI] instead of wrapping.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   resetn     in   synchronous reset, active-low
//   cmd_valid  in   command present
//   cmd_ready  out  high in IDLE; command taken on cmd_valid & cmd_ready
//   cmd_op     in   00 LOAD, 01 UP, 10 DOWN, 11 GOTO
//   cmd_arg    in   LOAD/GOTO value, or UP/DOWN step count
//   abort      in   stop the current move (only honoured while running)
//   c_out      out  current count
//   dir        out  1 = up, 0 = down (last/current move)
//   busy       out  high while a command is executing
//   done       out  one-cycle pulse on command completion
//   lim_hit    out  last command stopped/clamped at a limit; sticky until next accept

module counter_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_DIV = 1,
    parameter int unsigned LIMIT_LO = 0,
    parameter int unsigned LIMIT_HI = 2 ** WIDTH - 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] c_out,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             lim_hit
);

    localparam int unsigned PresW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PresW-1:0] PresMax = PresW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] LimLo   = WIDTH'(LIMIT_LO);
    localparam logic [WIDTH-1:0] LimHi   = WIDTH'(LIMIT_HI);

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpUp   = 2'b01,
        OpDown = 2'b10,
        OpGoto = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   remain_q, remain_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [PresW-1:0]   presc_q, presc_d;
    logic               dir_q, dir_d;
    logic               lim_q, lim_d;
    logic               goto_q, goto_d;

    op_e                op;
    logic               finished;
    logic               at_limit;

    assign op = op_e'(cmd_op);

    // A move is complete when the step budget is spent (UP/DOWN) or the
    // target has been reached (GOTO).
    assign finished = goto_q ? (count_q == target_q) : (remain_q == '0);

    // Stepping further in the current direction would leave the legal range.
    assign at_limit = dir_q ? (count_q == LimHi) : (count_q == LimLo);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        remain_d = remain_q;
        target_d = target_q;
        presc_d  = presc_q;
        dir_d    = dir_q;
        lim_d    = lim_q;
        goto_d   = goto_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    lim_d   = 1'b0;
                    presc_d = '0;
                    unique case (op)
                        OpLoad: begin
                            if (cmd_arg < LimLo) begin
                                count_d = LimLo;
                                lim_d   = 1'b1;
                            end else if (cmd_arg > LimHi) begin
                                count_d = LimHi;
                                lim_d   = 1'b1;
                            end else begin
                                count_d = cmd_arg;
                            end
                            state_d = StDone;
                        end
                        OpUp: begin
                            remain_d = cmd_arg;
                            dir_d    = 1'b1;
                            goto_d   = 1'b0;
                            state_d  = StRun;
                        end
                        OpDown: begin
                            remain_d = cmd_arg;
                            dir_d    = 1'b0;
                            goto_d   = 1'b0;
                            state_d  = StRun;
                        end
                        OpGoto: begin
                            target_d = cmd_arg;
                            dir_d    = (cmd_arg > count_q);
                            goto_d   = 1'b1;
                            state_d  = StRun;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StDone;
                end else if (finished) begin
                    state_d = StDone;
                end else if (presc_q < PresMax) begin
                    presc_d = presc_q + 1'b1;
                end else if (at_limit) begin
                    // Out-of-range targets and oversized step counts end here.
                    lim_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    count_d = dir_q ? (count_q + 1'b1) : (count_q - 1'b1);
                    if (!goto_q) begin
                        remain_d = remain_q - 1'b1;
                    end
                    presc_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            count_q  <= LimLo;
            remain_q <= '0;
            target_q <= '0;
            presc_q  <= '0;
            dir_q    <= 1'b1;
            lim_q    <= 1'b0;
            goto_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            remain_q <= remain_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            dir_q    <= dir_d;
            lim_q    <= lim_d;
            goto_q   <= goto_d;
        end
    end

    // DONE lasts exactly one cycle, so decoding it from the state register
    // yields a clean single-cycle pulse.
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign c_out     = count_q;
    assign dir       = dir_q;
    assign lim_hit   = lim_q;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cmd_valid [2];
    logic         cmd_ready [2];
    logic [1:0]   cmd_op    [2];
    logic [W-1:0] cmd_arg   [2];
    logic         abort     [2];
    logic [W-1:0] c_out     [2];
    logic         dir       [2];
    logic         busy      [2];
    logic         done      [2];
    logic         lim_hit   [2];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, GOTO = 2'b11;

    always #5 clk = ~clk;

    // Instance 0: defaults (STEP_DIV=1, full 0..255 range).
    counter_ctrl #(
        .WIDTH(W), .STEP_DIV(1), .LIMIT_LO(0), .LIMIT_HI(255)
    ) u_a (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_arg(cmd_arg[0]), .abort(abort[0]), .c_out(c_out[0]),
        .dir(dir[0]), .busy(busy[0]), .done(done[0]), .lim_hit(lim_hit[0])
    );

    // Instance 1: slow stepping and a narrow legal window 0x10..0x50.
    counter_ctrl #(
        .WIDTH(W), .STEP_DIV(3), .LIMIT_LO(16), .LIMIT_HI(80)
    ) u_b (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_arg(cmd_arg[1]), .abort(abort[1]), .c_out(c_out[1]),
        .dir(dir[1]), .busy(busy[1]), .done(done[1]), .lim_hit(lim_hit[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command on instance k once it is ready; returns just after the accept edge.
    task automatic send(input int k, input logic [1:0] op, input logic [W-1:0] arg);
        int guard = 0;
        while (!cmd_ready[k] && guard < 200) begin
            tick();
            guard++;
        end
        check("ready_wait", 32'(cmd_ready[k]), 32'd1);
        cmd_op[k]    = op;
        cmd_arg[k]   = arg;
        cmd_valid[k] = 1'b1;
        tick();
        cmd_valid[k] = 1'b0;
    endtask

    // Count edges after the accept edge until done is seen (0 = done right after accept).
    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (!done[k] && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_seen", 32'(done[k]), 32'd1);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic [W-1:0] exp_c;
        logic         exp_dir;
        logic         exp_lim;
        int           exp_cyc;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cyc;

        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_op[k]    = LOAD;
            cmd_arg[k]   = '0;
            abort[k]     = 1'b0;
        end
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        // Reset state.
        check("rst_c_a", 32'(c_out[0]), 32'h00);
        check("rst_c_b", 32'(c_out[1]), 32'h10);
        check("rst_dir", 32'(dir[0]), 32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_lim", 32'(lim_hit[0]), 32'd0);
        check("rst_ready", 32'(cmd_ready[1]), 32'd1);

        // Table-driven commands on instance 0 (STEP_DIV=1, limits 0x00..0xFF).
        vecs[0]  = '{LOAD, 8'h40, 8'h40, 1'b1, 1'b0, 0};
        vecs[1]  = '{UP,   8'd5,  8'h45, 1'b1, 1'b0, 6};
        vecs[2]  = '{DOWN, 8'd3,  8'h42, 1'b0, 1'b0, 4};
        vecs[3]  = '{GOTO, 8'h47, 8'h47, 1'b1, 1'b0, 6};
        vecs[4]  = '{GOTO, 8'h47, 8'h47, 1'b0, 1'b0, 1};
        vecs[5]  = '{UP,   8'd0,  8'h47, 1'b1, 1'b0, 1};
        vecs[6]  = '{LOAD, 8'hFE, 8'hFE, 1'b1, 1'b0, 0};
        vecs[7]  = '{UP,   8'd4,  8'hFF, 1'b1, 1'b1, 2};
        vecs[8]  = '{DOWN, 8'd2,  8'hFD, 1'b0, 1'b0, 3};
        vecs[9]  = '{LOAD, 8'h02, 8'h02, 1'b0, 1'b0, 0};
        vecs[10] = '{DOWN, 8'd5,  8'h00, 1'b0, 1'b1, 3};
        vecs[11] = '{GOTO, 8'h00, 8'h00, 1'b0, 1'b0, 1};

        for (int i = 0; i < 12; i++) begin
            send(0, vecs[i].op, vecs[i].arg);
            wait_done(0, cyc);
            check($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_c", i), 32'(c_out[0]), 32'(vecs[i].exp_c));
            check($sformatf("v%0d_dir", i), 32'(dir[0]), 32'(vecs[i].exp_dir));
            check($sformatf("v%0d_lim", i), 32'(lim_hit[0]), 32'(vecs[i].exp_lim));
            tick();
            check($sformatf("v%0d_pulse", i), 32'(done[0]), 32'd0);
            check($sformatf("v%0d_ready", i), 32'(cmd_ready[0]), 32'd1);
        end

        // Instance 1: UP 5 with STEP_DIV=3 steps on every third edge.
        send(1, LOAD, 8'h40);
        check("b_load_c", 32'(c_out[1]), 32'h40);
        tick();
        send(1, UP, 8'd5);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("b_up_c%0d", j), 32'(c_out[1]), 32'h40 + 32'(j / 3));
            check($sformatf("b_up_busy%0d", j), 32'(busy[1]), 32'd1);
            check($sformatf("b_up_done%0d", j), 32'(done[1]), 32'd0);
            tick();
        end
        check("b_up_done", 32'(done[1]), 32'd1);
        check("b_up_final", 32'(c_out[1]), 32'h45);
        check("b_up_dir", 32'(dir[1]), 32'd1);
        tick();
        check("b_up_pulse", 32'(done[1]), 32'd0);

        // UP 10 from 0x4E saturates at LIMIT_HI=0x50.
        send(1, LOAD, 8'h4E);
        tick();
        send(1, UP, 8'd10);
        wait_done(1, cyc);
        check("b_sat_cyc", 32'(cyc), 32'd9);
        check("b_sat_c", 32'(c_out[1]), 32'h50);
        check("b_sat_lim", 32'(lim_hit[1]), 32'd1);
        send(1, LOAD, 8'h30);
        check("b_lim_clear", 32'(lim_hit[1]), 32'd0);
        check("b_load30", 32'(c_out[1]), 32'h30);

        // LOAD outside the window clamps and flags.
        send(1, LOAD, 8'hFF);
        check("b_clamp_hi", 32'(c_out[1]), 32'h50);
        check("b_clamp_hi_lim", 32'(lim_hit[1]), 32'd1);
        send(1, LOAD, 8'h05);
        check("b_clamp_lo", 32'(c_out[1]), 32'h10);
        check("b_clamp_lo_lim", 32'(lim_hit[1]), 32'd1);

        // abort in IDLE is ignored.
        tick();
        abort[1] = 1'b1;
        tick();
        tick();
        abort[1] = 1'b0;
        check("idle_abort_busy", 32'(busy[1]), 32'd0);
        check("idle_abort_c", 32'(c_out[1]), 32'h10);

        // GOTO 0x10 from 0x20, abort after the 4th step, with a held command pending.
        send(0, LOAD, 8'h20);
        tick();
        send(0, GOTO, 8'h10);
        cmd_op[0]    = LOAD;
        cmd_arg[0]   = 8'h99;
        cmd_valid[0] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("goto_c%0d", j), 32'(c_out[0]), 32'h20 - 32'(j));
            check($sformatf("goto_ready%0d", j), 32'(cmd_ready[0]), 32'd0);
        end
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("abort_done", 32'(done[0]), 32'd1);
        check("abort_c", 32'(c_out[0]), 32'h1C);
        check("abort_dir", 32'(dir[0]), 32'd0);
        check("abort_lim", 32'(lim_hit[0]), 32'd0);
        tick();
        check("held_not_taken", 32'(c_out[0]), 32'h1C);
        check("held_ready", 32'(cmd_ready[0]), 32'd1);
        tick();
        cmd_valid[0] = 1'b0;
        check("held_taken", 32'(c_out[0]), 32'h99);
        check("held_done", 32'(done[0]), 32'd1);
        tick();

        // Reset in the middle of a DOWN move.
        send(0, LOAD, 8'h80);
        tick();
        send(0, DOWN, 8'd20);
        tick();
        tick();
        tick();
        check("pre_rst_c", 32'(c_out[0]), 32'h7D);
        resetn = 1'b0;
        tick();
        check("mid_rst_c", 32'(c_out[0]), 32'h00);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_done", 32'(done[0]), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready[0]), 32'd1);
        check("mid_rst_dir", 32'(dir[0]), 32'd1);
        check("mid_rst_c_b", 32'(c_out[1]), 32'h10);
        resetn = 1'b1;
        tick();
        check("post_rst_done", 32'(done[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
